spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on i_sclk/i_mosi/i_cs_n (legal range 2..4).
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF, byte shifted out when no TX data is loaded.
REQ-003 SHALL have port i_clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_sclk  input  1  SPI clock from master, asynchronous to i_clk.
REQ-006 SHALL have port i_mosi  input  1  SPI data from master.
REQ-007 SHALL have port i_cs_n  input  1  SPI chip select, active-low.
REQ-008 SHALL have port o_miso  output  1  SPI data to master.
REQ-009 SHALL have port o_miso_oe  output  1  MISO drive enable; the top level tri-states when low.
REQ-010 SHALL have port i_tx_valid  input  1  TX byte offered.
REQ-011 SHALL have port i_tx_byte  input  8  TX byte.
REQ-012 SHALL have port o_tx_ready  output  1  TX holding register empty.
REQ-013 SHALL have port o_rx_valid  output  1  one-cycle pulse, o_rx_byte holds a new byte.
REQ-014 SHALL have port o_rx_byte  output  8  last complete received byte.
REQ-015 SHALL have port o_tx_underrun  output  1  one-cycle pulse, IDLE_BYTE substituted (see REQ-034).

Function
REQ-016 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, with any number of back-to-back bytes per CS assertion.
REQ-017 SHALL pass i_sclk, i_mosi and i_cs_n through SYNC_STAGES flops and detect edges on the synchronized sclk and cs_n only.
REQ-018 SHALL support f(i_sclk) <= f(i_clk)/8; behaviour at higher rates is undefined.
REQ-019 SHALL implement FSM IDLE/ACTIVE: IDLE->ACTIVE on synchronized cs_n falling; ACTIVE->IDLE on synchronized cs_n rising.
REQ-020 SHALL drive o_miso_oe high exactly while in ACTIVE.
REQ-021 SHALL, on IDLE->ACTIVE, load the TX shift register from the holding register if it is full (marking it empty), otherwise from IDLE_BYTE, and clear the 3-bit bit counter.
REQ-022 SHALL drive o_miso from TX shift register bit 7 at all times.
REQ-023 SHALL, on each synchronized sclk rising edge in ACTIVE, shift synchronized mosi into the RX shift register LSB and increment the bit counter (wraps 7->0).
REQ-024 SHALL, on each synchronized sclk falling edge in ACTIVE, shift the TX register left by one, except after the 8th bit.
REQ-025 SHALL, after the 8th bit, reload the TX register on that falling edge per the REQ-021 rule instead of shifting.
REQ-026 SHALL copy the RX register to o_rx_byte and pulse o_rx_valid for one i_clk cycle on the i_clk cycle after the 8th sclk rising edge is detected.
REQ-027 SHALL hold o_rx_byte stable until the next complete byte.
REQ-028 SHALL assert o_tx_ready while the holding register is empty and accept i_tx_byte when i_tx_valid && o_tx_ready.
REQ-029 SHALL ignore i_tx_valid while o_tx_ready is low.
REQ-030 SHALL give a holding-register transfer into the TX shift register priority over a write in the same cycle; the write is then accepted on the next cycle.
REQ-031 SHALL, on cs_n rising mid-byte: discard the partial RX byte (no o_rx_valid), discard the partial TX byte, clear the bit counter, and keep the holding register contents.
REQ-032 SHALL ignore sclk edges while in IDLE.

Reset
REQ-033 SHALL, while i_rst_n is low: FSM=IDLE, synchronizer flops cs_n=1 and sclk/mosi=0, counters=0, TX register=IDLE_BYTE, holding register empty, o_tx_ready=1, o_rx_valid=0, o_rx_byte=8'h00, o_miso_oe=0, o_tx_underrun=0; reset mid-transfer abandons the frame.

Configuration
REQ-034 SHALL, with macro SPI_SLAVE_UNDERRUN_EN defined, pulse o_tx_underrun for one cycle each time IDLE_BYTE is loaded because the holding register is empty; without the macro, o_tx_underrun SHALL be tied to 0 and no detection logic SHALL be synthesized.

Verification
REQ-035 SHALL cover: load 8'h3E, master sends 8'hA5 at f(i_clk)/8 -> o_rx_byte=8'hA5 with a single o_rx_valid pulse; master receives 8'h3E.
REQ-036 SHALL cover: no TX loaded, master sends 8'h00 -> master receives 8'hFF; o_tx_underrun pulses once with the macro and stays 0 without it.
REQ-037 SHALL cover: three bytes 8'h01/8'h02/8'h03 in one CS, TX refilled on each o_tx_ready -> three o_rx_valid pulses in order, master receives the refilled bytes in order.
REQ-038 SHALL cover: cs_n raised after 5 bits of 8'hF0, then a full byte 8'h5A -> no o_rx_valid for the partial byte, then o_rx_byte=8'h5A.
REQ-039 SHALL cover: i_rst_n pulsed low mid-byte -> all outputs at their REQ-033 values; the next full transfer 8'hC3 is received correctly.
REQ-040 SHALL cover: i_tx_valid held high while o_tx_ready=0 -> second byte not accepted until the holding register empties.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 slave: synchronizes the SPI pins into i_clk, shifts MSB-first bytes
// through RX/TX shift registers, with a one-deep TX holding register.
// Optional build macro SPI_SLAVE_UNDERRUN_EN enables the TX underrun pulse.

// state     | meaning
// ST_IDLE   | chip select high, MISO tri-stated, sclk edges ignored
// ST_ACTIVE | chip select low, shifting bytes, MISO driven
module spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_cs_n,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_byte,
  output logic       o_tx_underrun
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  logic       sclk_s, mosi_s, cs_s;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic       start_evt, stop_evt, bit_rise, bit_fall, load_evt;
  logic       miso_oe_d;

  logic [2:0] bit_cnt;
  logic       last_bit;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] hold_byte;
  logic       hold_full;
  logic       rx_valid_q;
  logic [7:0] rx_byte_q;

  // cs_n synchronizer resets to 1 so reset release never looks like a select
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    miso_oe_d = 1'b0;
    start_evt = 1'b0;
    stop_evt  = 1'b0;
    bit_rise  = 1'b0;
    bit_fall  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_ACTIVE;
          start_evt = 1'b1;
        end
      end
      ST_ACTIVE: begin
        miso_oe_d = 1'b1;
        if (cs_rise) begin
          state_d  = ST_IDLE;
          stop_evt = 1'b1;
        end else begin
          bit_rise = sclk_rise;
          bit_fall = sclk_fall;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // the falling edge that closes a byte reloads instead of shifting
  assign load_evt = start_evt | (bit_fall & last_bit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt  <= 3'd0;
      last_bit <= 1'b0;
      rx_shift <= 7'd0;
    end else if (stop_evt || start_evt) begin
      bit_cnt  <= 3'd0;
      last_bit <= 1'b0;
    end else if (bit_rise) begin
      rx_shift <= {rx_shift[5:0], mosi_s};
      bit_cnt  <= bit_cnt + 3'd1;
      last_bit <= (bit_cnt == 3'd7);
    end else if (bit_fall) begin
      last_bit <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_shift <= IDLE_BYTE;
    end else if (load_evt) begin
      tx_shift <= hold_full ? hold_byte : IDLE_BYTE;
    end else if (bit_fall) begin
      tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  // a transfer out of the holding register wins; ready is low while it is full
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_byte <= 8'h00;
      hold_full <= 1'b0;
    end else if (load_evt && hold_full) begin
      hold_full <= 1'b0;
    end else if (i_tx_valid && !hold_full) begin
      hold_byte <= i_tx_byte;
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'h00;
    end else begin
      rx_valid_q <= bit_rise && (bit_cnt == 3'd7);
      if (bit_rise && (bit_cnt == 3'd7)) rx_byte_q <= {rx_shift, mosi_s};
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) underrun_q <= 1'b0;
    else          underrun_q <= load_evt & ~hold_full;
  end

  assign o_tx_underrun = underrun_q;
`else
  assign o_tx_underrun = 1'b0;
`endif

  assign o_miso     = tx_shift[7];
  assign o_miso_oe  = miso_oe_d;
  assign o_tx_ready = ~hold_full;
  assign o_rx_valid = rx_valid_q;
  assign o_rx_byte  = rx_byte_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master, a byte-level TX model and an
// RX scoreboard drained by a monitor on o_rx_valid.
module tb_spi_slave;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;
`ifdef SPI_SLAVE_UNDERRUN_EN
  localparam bit UND_EN = 1'b1;
`else
  localparam bit UND_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, mosi, cs_n;
  logic       miso, miso_oe;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready, rx_valid, tx_underrun;
  logic [7:0] rx_byte;

  spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(IDLE_BYTE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_mosi(mosi), .i_cs_n(cs_n),
    .o_miso(miso), .o_miso_oe(miso_oe), .i_tx_valid(tx_valid), .i_tx_byte(tx_byte),
    .o_tx_ready(tx_ready), .o_rx_valid(rx_valid), .o_rx_byte(rx_byte),
    .o_tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] mon_exp;
  bit         m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  int         und_exp = 0;
  int         und_seen = 0;
  logic [7:0] last_rx = 8'h00;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // each load takes the holding byte if one is waiting, else substitutes IDLE_BYTE
  function automatic logic [7:0] model_load();
    if (m_full) begin
      m_full = 1'b0;
      return m_hold;
    end
    und_exp++;
    return IDLE_BYTE;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_underrun) und_seen++;
      if (rx_valid) begin
        if (rx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected got %h expected no byte at %0t", rx_byte, $time);
        end else begin
          mon_exp = rx_exp_q.pop_front();
          check("rx_byte", rx_byte, mon_exp);
        end
      end
    end
  end

  task automatic tb_write(input logic [7:0] b);
    check("tx_ready_before_write", {7'd0, tx_ready}, {7'd0, !m_full});
    if (tx_ready) begin
      tx_valid = 1'b1;
      tx_byte  = b;
      @(negedge clk);
      tx_valid = 1'b0;
      m_full   = 1'b1;
      m_hold   = b;
    end
  endtask

  task automatic run_frame(input int n, input logic [7:0] mo [4], input logic [3:0] rf_mask,
                           input logic [7:0] rf [4], input int half);
    logic [7:0] exp_tx, exp_next, got;
    cs_n   = 1'b0;
    exp_tx = model_load();
    for (int k = 0; k < n; k++) begin
      rx_exp_q.push_back(mo[k]);
      got = 8'h00;
      for (int b = 7; b >= 0; b--) begin
        mosi = mo[k][b];
        wait_clk(half);
        got  = {got[6:0], miso};
        sclk = 1'b1;
        if (k == 0 && b == 7) check("miso_oe_active", {7'd0, miso_oe}, 8'd1);
        wait_clk(half);
        sclk = 1'b0;
      end
      wait_clk(5);
      exp_next = model_load();
      check("miso_byte", got, exp_tx);
      if (rf_mask[k]) tb_write(rf[k]);
      exp_tx  = exp_next;
      last_rx = mo[k];
    end
    wait_clk(half);
    cs_n = 1'b1;
    wait_clk(8);
    check("miso_oe_idle", {7'd0, miso_oe}, 8'd0);
  endtask

  task automatic partial_frame(input int nbits, input logic [7:0] b, input int half);
    cs_n = 1'b0;
    void'(model_load());
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      wait_clk(half);
      sclk = 1'b1;
      wait_clk(half);
      sclk = 1'b0;
    end
    wait_clk(half);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic check_reset_outputs();
    check("rst_miso_oe", {7'd0, miso_oe}, 8'd0);
    check("rst_tx_ready", {7'd0, tx_ready}, 8'd1);
    check("rst_rx_valid", {7'd0, rx_valid}, 8'd0);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_underrun", {7'd0, tx_underrun}, 8'd0);
    check("rst_miso", {7'd0, miso}, {7'd0, IDLE_BYTE[7]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] mo [4];
  logic [7:0] rf [4];
  int         hold_n;
  bit         hold_ok;

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; tx_byte = 8'h00;
    for (int i = 0; i < 4; i++) begin mo[i] = 8'h00; rf[i] = 8'h00; end
    wait_clk(3);
    check_reset_outputs();
    rst_n = 1'b1;
    wait_clk(4);

    // preloaded byte out, A5 in, at the fastest legal sclk
    tb_write(8'h3E);
    mo[0] = 8'hA5;
    run_frame(1, mo, 4'b0000, rf, 4);

    // nothing loaded: master sees IDLE_BYTE
    mo[0] = 8'h00;
    run_frame(1, mo, 4'b0000, rf, 4);

    // three back-to-back bytes with refill after each of the first two
    tb_write(8'h10);
    mo[0] = 8'h01; mo[1] = 8'h02; mo[2] = 8'h03;
    rf[0] = 8'h20; rf[1] = 8'h30;
    run_frame(3, mo, 4'b0011, rf, 5);

    // aborted byte leaves rx_byte alone, next byte lands normally
    partial_frame(5, 8'hF0, 4);
    check("rx_byte_hold_after_abort", rx_byte, last_rx);
    mo[0] = 8'h5A;
    run_frame(1, mo, 4'b0000, rf, 4);

    // second write held off while the holding register is full
    tb_write(8'hA1);
    tx_valid = 1'b1;
    tx_byte  = 8'hB2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("tx_ready_full", {7'd0, tx_ready}, 8'd0);
    end
    mo[0] = 8'h6C; mo[1] = 8'h93;
    hold_ok = 1'b0;
    fork
      run_frame(2, mo, 4'b0000, rf, 6);
      begin
        hold_n = 0;
        while (!tx_ready && hold_n < 60) begin @(negedge clk); hold_n++; end
        if (tx_ready) begin
          m_full = 1'b1;
          m_hold = 8'hB2;
          hold_ok = 1'b1;
          @(negedge clk);
        end
        tx_valid = 1'b0;
      end
    join
    check("held_write_accepted", {7'd0, hold_ok}, 8'd1);

    // reset in the middle of a byte
    cs_n = 1'b0;
    void'(model_load());
    for (int i = 0; i < 3; i++) begin
      mosi = i[0];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    mosi = 1'b1;
    wait_clk(4);
    sclk = 1'b1;
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    m_full = 1'b0;
    last_rx = 8'h00;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    mo[0] = 8'hC3;
    run_frame(1, mo, 4'b0000, rf, 4);

    for (int t = 0; t < 10; t++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        mo[i] = 8'($urandom);
        rf[i] = 8'($urandom);
      end
      if (!m_full && $urandom_range(0, 1) == 1) tb_write(8'($urandom));
      run_frame(n, mo, 4'($urandom), rf, $urandom_range(4, 8));
      wait_clk($urandom_range(2, 10));
    end

    wait_clk(20);
    check("rx_queue_drained", 8'(rx_exp_q.size()), 8'd0);
    check("underrun_count", 8'(und_seen), UND_EN ? 8'(und_exp) : 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
